// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame constants and parity helper for the uart_parity_link slice
// Ports: none (package)
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int FRAME_BITS = 11;
  localparam logic [31:0] DIV_MIN = 32'd2;
  function automatic logic par8(input logic [7:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/uart_parity_link_if.sv
// uart_parity_link_if: byte-level host bus of the UART (divisor, tx request, rx result)
// Ports: none; master = host side, slave = UART side
interface uart_parity_link_if;
  logic [31:0] baud_div;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_error;
  modport master(output baud_div, tx_data, tx_start, input tx_busy, rx_data, rx_valid, rx_error);
  modport slave(input baud_div, tx_data, tx_start, output tx_busy, rx_data, rx_valid, rx_error);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop input synchroniser and mid-bit sampling frame receiver with parity check
// Ports: clk, rst_n (async active-low), div (cycles per bit, already >=2), rx_serial (async line),
//        rx_data, rx_valid (1-cycle pulse), rx_error
// UART_STOP_CHECK_EN: when defined a low stop bit flags rx_error and holds off re-arming until the line is high
module uart_rx_core
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] div,
  input  logic        rx_serial,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_error
);
  uart_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0] sh_q, sh_d, data_d;
  logic [2:0] idx_q, idx_d;
  logic s1_q, s2_q, prev_q, hold_q, hold_d, pbit_q, pbit_d, err_d, valid_d;
  logic tick, fall, perr, ferr;
  assign tick = cnt_q == '0;
  assign fall = prev_q & ~s2_q;
  assign perr = par8(sh_q, PARITY_ODD) != pbit_q;
`ifdef UART_STOP_CHECK_EN
  assign ferr = ~s2_q;
`else
  assign ferr = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      prev_q   <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_MIN;
      sh_q     <= '0;
      idx_q    <= '0;
      pbit_q   <= 1'b0;
      hold_q   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      s1_q     <= rx_serial;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      pbit_q   <= pbit_d;
      hold_q   <= hold_d;
      rx_data  <= data_d;
      rx_valid <= valid_d;
      rx_error <= err_d;
    end
  end
  // START counts half a bit to land mid-bit; every later sample is a full bit apart.
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == IDLE ? cnt_q : tick ? div_q - 32'd1 : cnt_q - 32'd1;
    div_d   = div_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    pbit_d  = pbit_q;
    hold_d  = hold_q;
    data_d  = rx_data;
    err_d   = rx_error;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = hold_q & ~s2_q;
        if (fall && !hold_q) begin
          state_d = START;
          div_d   = div;
          cnt_d   = div >> 1;
        end
      end
      START: if (tick) begin
        state_d = s2_q ? IDLE : DATA;
        idx_d   = '0;
      end
      DATA: if (tick) begin
        state_d = idx_q == 3'd7 ? PARITY : DATA;
        sh_d    = {s2_q, sh_q[7:1]};
        idx_d   = idx_q + 3'd1;
      end
      PARITY: if (tick) begin
        state_d = STOP;
        pbit_d  = s2_q;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        data_d  = sh_q;
        err_d   = perr | ferr;
        valid_d = 1'b1;
        hold_d  = ferr;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: start-edge detect and 11-bit frame transmitter (start, 8 data LSB first, parity, stop)
// Ports: clk, rst_n (async active-low), div (cycles per bit, already >=2), tx_data, tx_start,
//        tx_serial (registered line, idles high), tx_busy
module uart_tx_core
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] div,
  input  logic [7:0]  tx_data,
  input  logic        tx_start,
  output logic        tx_serial,
  output logic        tx_busy
);
  uart_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d, div_q, div_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;
  logic par_q, par_d, start_q, ser_d, busy_d, tick, start_edge;
  assign tick = cnt_q == '0;
  assign start_edge = tx_start & ~start_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_MIN;
      sh_q      <= '0;
      idx_q     <= '0;
      par_q     <= 1'b0;
      start_q   <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
      start_q   <= tx_start;
      tx_serial <= ser_d;
      tx_busy   <= busy_d;
    end
  end
  // Each state holds the line for div_q cycles: the counter reloads div_q-1 whenever it hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = state_q == IDLE ? cnt_q : tick ? div_q - 32'd1 : cnt_q - 32'd1;
    div_d   = div_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    par_d   = par_q;
    ser_d   = tx_serial;
    busy_d  = tx_busy;
    case (state_q)
      IDLE: if (start_edge) begin
        state_d = START;
        div_d   = div;
        cnt_d   = div - 32'd1;
        sh_d    = tx_data;
        par_d   = par8(tx_data, PARITY_ODD);
        ser_d   = 1'b0;
        busy_d  = 1'b1;
      end
      START: if (tick) begin
        state_d = DATA;
        ser_d   = sh_q[0];
        sh_d    = sh_q >> 1;
        idx_d   = '0;
      end
      DATA: if (tick) begin
        state_d = idx_q == 3'd7 ? PARITY : DATA;
        ser_d   = idx_q == 3'd7 ? par_q : sh_q[0];
        sh_d    = sh_q >> 1;
        idx_d   = idx_q + 3'd1;
      end
      PARITY: if (tick) begin
        state_d = STOP;
        ser_d   = 1'b1;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_parity_link.sv
// uart_parity_link: full-duplex 8-bit UART with parity between a host bus and the serial pins
// Ports: clk, rst_n (async assert, sync release), host (uart_parity_link_if.slave: baud_div, tx_data,
//        tx_start, tx_busy, rx_data, rx_valid, rx_error), tx_serial, rx_serial
// Optional: UART_STOP_CHECK_EN enables stop-bit framing error reporting
module uart_parity_link
  import uart_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_parity_link_if.slave        host,
  output logic                     tx_serial,
  input  logic                     rx_serial
);
  logic [1:0] rst_sync;
  logic [31:0] div;
  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  end
  assign div = host.baud_div < DIV_MIN ? DIV_MIN : host.baud_div;
  uart_tx_core #(.PARITY_ODD(PARITY_ODD)) u_tx (
    .clk       (clk),
    .rst_n     (rst_sync[1]),
    .div       (div),
    .tx_data   (host.tx_data),
    .tx_start  (host.tx_start),
    .tx_serial (tx_serial),
    .tx_busy   (host.tx_busy)
  );
  uart_rx_core #(.PARITY_ODD(PARITY_ODD)) u_rx (
    .clk       (clk),
    .rst_n     (rst_sync[1]),
    .div       (div),
    .rx_serial (rx_serial),
    .rx_data   (host.rx_data),
    .rx_valid  (host.rx_valid),
    .rx_error  (host.rx_error)
  );
endmodule

// File: tb/tb_uart_parity_link.sv
// tb_uart_parity_link: directed scoreboard bench for uart_parity_link (even DUT plus odd-parity loopback shadow)
module tb_uart_parity_link;
  import uart_pkg::*;
`ifdef UART_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, loop = 1'b1, rx_drv = 1'b1;
  logic tx_e, tx_o, rx_e;
  int vectors = 0, miscompares = 0, valid_e = 0, valid_o = 0;
  logic [8:0] sb_e[$], sb_o[$];
  logic [8:0] xe, xo;
  uart_parity_link_if he();
  uart_parity_link_if ho();
  assign ho.baud_div = he.baud_div;
  assign ho.tx_data  = he.tx_data;
  assign ho.tx_start = he.tx_start;
  assign rx_e = loop ? tx_e : rx_drv;
  uart_parity_link #(.PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .host(he.slave), .tx_serial(tx_e), .rx_serial(rx_e));
  uart_parity_link #(.PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .host(ho.slave), .tx_serial(tx_o), .rx_serial(tx_o));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int b);
    return b == 0 ? 1'b0 : b <= 8 ? d[b-1] : b == 9 ? ((^d) ^ odd) : 1'b1;
  endfunction

  always @(negedge clk) if (he.rx_valid === 1'b1) begin
    valid_e++;
    if (sb_e.size() == 0) check("rx_spurious_e", 32'(he.rx_valid), 32'd0);
    else begin
      xe = sb_e.pop_front();
      check("rx_data_e", 32'(he.rx_data), 32'(xe[7:0]));
      check("rx_error_e", 32'(he.rx_error), 32'(xe[8]));
    end
  end

  always @(negedge clk) if (ho.rx_valid === 1'b1) begin
    valid_o++;
    if (sb_o.size() == 0) check("rx_spurious_o", 32'(ho.rx_valid), 32'd0);
    else begin
      xo = sb_o.pop_front();
      check("rx_data_o", 32'(ho.rx_data), 32'(xo[7:0]));
      check("rx_error_o", 32'(ho.rx_error), 32'(xo[8]));
    end
  end

  // Starts a frame on a 0->1 tx_start edge and checks every bit mid-bit on both DUTs plus busy length.
  // bump: mid-frame re-edge of tx_start with changed data and divisor, all of which must be ignored.
  task automatic send(input logic [7:0] d, input int div, input bit bump);
    int t = 0, target;
    he.baud_div = div;
    he.tx_data = d;
    he.tx_start = 1'b1;
    if (loop) sb_e.push_back({1'b0, d});
    sb_o.push_back({1'b0, d});
    @(posedge clk);
    for (int b = 0; b < FRAME_BITS; b++) begin
      target = b * div + div / 2;
      repeat (target - t) @(posedge clk);
      t = target;
      @(negedge clk);
      check($sformatf("tx_bit%0d_e", b), 32'(tx_e), 32'(exp_bit(d, 1'b0, b)));
      check($sformatf("tx_bit%0d_o", b), 32'(tx_o), 32'(exp_bit(d, 1'b1, b)));
      check($sformatf("tx_busy_bit%0d", b), 32'(he.tx_busy), 32'd1);
      if (bump && b == 2) begin
        he.tx_start = 1'b0;
        he.baud_div = 3;
        he.tx_data = ~d;
      end
      if (bump && b == 3) he.tx_start = 1'b1;
    end
    repeat (FRAME_BITS * div - 1 - t) @(posedge clk);
    @(negedge clk);
    check("tx_busy_last", 32'(he.tx_busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("tx_busy_drop", 32'(he.tx_busy), 32'd0);
    check("tx_idle_line", 32'(tx_e), 32'd1);
    he.tx_start = 1'b0;
    he.baud_div = div;
    he.tx_data = d;
    @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input int div, input bit flip, input bit stop);
    logic [10:0] f;
    f = {stop, (^d) ^ flip, d, 1'b0};
    for (int b = 0; b < FRAME_BITS; b++) begin
      rx_drv = f[b];
      repeat (div) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx(input string tag, input int ne, input int no, input int budget);
    for (int k = 0; k < budget && (valid_e < ne || valid_o < no); k++) @(negedge clk);
    check({tag, "_valid_cnt_e"}, valid_e, ne);
    check({tag, "_valid_cnt_o"}, valid_o, no);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    he.baud_div = 10;
    he.tx_data = 8'h00;
    he.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_e), 32'd1);
    check("rst_tx_busy", 32'(he.tx_busy), 32'd0);
    check("rst_rx_data", 32'(he.rx_data), 32'd0);
    check("rst_rx_valid", 32'(he.rx_valid), 32'd0);
    check("rst_rx_error", 32'(he.rx_error), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h0A, 10, 1'b0);
    wait_rx("t1", 1, 1, 200);
    send(8'h07, 16, 1'b0);
    wait_rx("t2", 2, 2, 300);
    loop = 1'b0;
    he.baud_div = 12;
    sb_e.push_back({1'b1, 8'hA5});
    drive_frame(8'hA5, 12, 1'b1, 1'b1);
    wait_rx("t3", 3, 2, 300);
    he.baud_div = 10;
    repeat (5) @(negedge clk);
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_valid", valid_e, 3);
    sb_e.push_back({1'b0, 8'h5A});
    drive_frame(8'h5A, 10, 1'b0, 1'b1);
    wait_rx("t5_after_glitch", 4, 2, 200);
    repeat (5) @(negedge clk);
    sb_e.push_back({STOP_CHECK, 8'h3C});
    drive_frame(8'h3C, 10, 1'b0, 1'b0);
    wait_rx("t6", 5, 2, 200);
    repeat (5) @(negedge clk);
    sb_e.push_back({1'b0, 8'hC3});
    drive_frame(8'hC3, 10, 1'b0, 1'b1);
    wait_rx("t6_rearm", 6, 2, 200);
    loop = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h55, 8, 1'b1);
    repeat (16) @(negedge clk);
    check("t4_no_second_busy", 32'(he.tx_busy), 32'd0);
    check("t4_no_second_line", 32'(tx_e), 32'd1);
    wait_rx("t4", 7, 3, 200);
    send(8'h96, 8, 1'b0);
    wait_rx("t4_next", 8, 4, 200);
    he.baud_div = 10;
    he.tx_data = 8'hF0;
    he.tx_start = 1'b1;
    repeat (45) @(negedge clk);
    check("t5_busy_before_rst", 32'(he.tx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx_serial", 32'(tx_e), 32'd1);
    check("t5_rst_tx_busy", 32'(he.tx_busy), 32'd0);
    he.tx_start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_no_valid_e", valid_e, 8);
    check("t5_no_valid_o", valid_o, 4);
    check("t5_rx_data_cleared", 32'(he.rx_data), 32'd0);
    check("t5_line_idle", 32'(tx_e), 32'd1);
    check("sb_empty_e", sb_e.size(), 0);
    check("sb_empty_o", sb_o.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
